shift_reg_tap: RTL and testbench
================================

Name: shift_reg_tap

Overview:
- Parametrised successor to the plain fixed-depth shift register: a delay line with per-stage valid tracking, shift enable (stall), synchronous clear, runtime-selectable output tap and occupancy count.
- Used for latency matching between pipelines of different or runtime-configurable depth, and for retiming valid-qualified data, without building a full FIFO.

Parameters:
- dtype, logic, type of one data word.
- Depth, 4, number of register stages; must be >= 1. Depth == 0 is a fatal elaboration error.
- TapW, $clog2(Depth+1), width of tap_sel_i; derived, do not override.
- CntW, $clog2(Depth+1), width of fill_o; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clr_i  in  1  synchronous clear of all stages.
- en_i  in  1  shift enable; 0 = hold all stages.
- valid_i  in  1  d_i qualifier.
- d_i  in  dtype  input word.
- tap_sel_i  in  TapW  delay in enabled cycles: 0 .. Depth.
- valid_o  out  1  valid of the selected tap.
- d_o  out  dtype  data of the selected tap.
- fill_o  out  CntW  number of stages currently holding valid data.

Behaviour:
- Reset (rst_ni = 0, asynchronous): all stage data '0, all stage valids 0, fill_o = 0. Reset mid-operation discards contents immediately.
- Stage k (1..Depth) holds data_q[k] and vld_q[k].
- Shift when en_i = 1 and clr_i = 0:
  - data_q[1] <= d_i and vld_q[1] <= valid_i.
  - data_q[k] <= data_q[k-1] and vld_q[k] <= vld_q[k-1].
  - The word in stage Depth is dropped.
- Hold when en_i = 0: all stages and fill_o keep their values; valid_i and d_i are ignored.
- clr_i = 1: all data '0, all valids 0, fill 0 at the next edge. clr_i has priority over en_i, and any input presented in the same cycle is discarded.
- Tap select (combinational):
  - tap_sel_i = 0: d_o = d_i, valid_o = valid_i (pass-through).
  - tap_sel_i = k, 1..Depth: outputs are stage k.
  - tap_sel_i > Depth: clamped to Depth.
  - A change to tap_sel_i takes effect in the same cycle. No output glitch filtering; consumers sample on the clock.
- Latency: with en_i held at 1, a word entered at edge t appears at tap k after k rising edges.
- fill_o is registered: fill_next = fill_q + (en & valid_i) - (en & vld_q[Depth]). It never exceeds Depth and never underflows; an assertion checks 0 <= fill_o <= Depth.
- fill_o counts valids in all stages regardless of tap_sel_i.
- Depth == 1 uses the same logic; there is no special case beyond the shift being a single stage.
- dtype values are copied unchanged; no arithmetic on data.

Optional Feature:
- Macro: SHIFT_REG_TAP_DATA_GATE_EN.
- Defined: a stage's data register loads only when en_i = 1 and the incoming valid is 1; otherwise it holds its old data. Valid bits shift exactly as described above. d_o is defined only when valid_o = 1. This mode exists to reduce toggle power and aid clock gating. clr_i still zeroes the data.
- Undefined: data shifts on every enabled cycle regardless of valid. d_o at tap k always equals d_i from k enabled cycles earlier.

Decomposition:
- Package shift_reg_pkg holds:
  - function cnt_width(depth), returning $clog2(depth+1), with a minimum of 1.
  - typedef tap_mode_e {TAP_PASS, TAP_STAGE} for the assertion/cover helpers.
- One natural sub-module, shift_reg_tap_stage: a single stage of data plus valid with en, clr and the gating macro. The top level instantiates it Depth times in a generate loop and adds the tap mux and the fill counter.
- All flops are built with the team's register macros (async reset, clear variant).

Test Plan:
- Reset, then Depth=4, tap_sel=4, en=1: drive valid words 0x1..0x8 one per cycle -> 0x1 appears on d_o with valid_o=1 on the 4th edge after entry; fill_o rises 1,2,3,4 and then stays at 4.
- en=0 for 3 cycles mid-stream with the line holding 0x3..0x6 -> outputs and fill_o frozen; after en=1 the sequence resumes with 0x3 next and no loss or duplication.
- clr_i=1 together with en_i=1, valid_i=1, d_i=0xA -> next cycle fill_o=0, valid_o=0 at every tap, and 0xA never appears.
- Sweep tap_sel 0..5 on a full line holding 0x4,0x3,0x2,0x1 (stage1..4), with valid_i=1 and d_i=0x5 -> d_o = 0x5,0x4,0x3,0x2,0x1,0x1 (5 clamped to 4).
- Alternating valid_i 1/0 with data 0xF0..0xF7 -> fill_o settles at 2 for Depth=4. With SHIFT_REG_TAP_DATA_GATE_EN defined, stage data holds its last valid word while valid=0; without the macro, invalid words are shifted through.
- Deassert rst_ni for one cycle mid-stream with fill=3 -> asynchronous: all outputs 0 immediately, and fill_o=0 after release.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared helpers for the tapped shift register: counter width function and tap mode enum.
package shift_reg_pkg;

    typedef enum logic {
        TAP_PASS  = 1'b0,
        TAP_STAGE = 1'b1
    } tap_mode_e;

    // Width needed to hold 0..depth, never narrower than one bit.
    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/shift_reg_tap_stage.sv
// One delay stage: data word plus valid bit, with hold, clear and optional data gating
// (SHIFT_REG_TAP_DATA_GATE_EN: data loads only when the incoming valid is set).
module shift_reg_tap_stage
    import shift_reg_pkg::*;
#(
    parameter type dtype = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic prev_valid,
    input  dtype prev_data,
    output logic valid,
    output dtype data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (en) begin
            valid <= prev_valid;
`ifdef SHIFT_REG_TAP_DATA_GATE_EN
            // Invalid words leave the data register untouched to save toggles.
            if (prev_valid) begin
                data <= prev_data;
            end
`else
            data <= prev_data;
`endif
        end
    end

endmodule

// File: rtl/shift_reg_tap.sv
// Valid-tracking delay line with stall, synchronous clear, runtime tap select and occupancy count.
// Optional macro SHIFT_REG_TAP_DATA_GATE_EN gates stage data loads on valid.
module shift_reg_tap
    import shift_reg_pkg::*;
#(
    parameter type dtype = logic,
    parameter int  Depth = 4,
    parameter int  TapW  = $clog2(Depth + 1),
    parameter int  CntW  = cnt_width(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            valid_i,
    input  dtype            d_i,
    input  logic [TapW-1:0] tap_sel_i,
    output logic            valid_o,
    output dtype            d_o,
    output logic [CntW-1:0] fill_o
);

    if (Depth < 1) begin : g_depth_check
        $fatal(1, "shift_reg_tap: Depth must be >= 1");
    end

    // Index 0 is the live input so stage k always reads entry k-1.
    dtype             data_q [Depth+1];
    logic [Depth:0]   vld_q;
    logic [CntW-1:0]  fill_q;
    logic [CntW-1:0]  fill_d;
    logic [TapW-1:0]  sel_c;
    tap_mode_e        tap_mode;

    assign data_q[0] = d_i;
    assign vld_q[0]  = valid_i;

    for (genvar k = 1; k <= Depth; k++) begin : g_stage
        shift_reg_tap_stage #(
            .dtype(dtype)
        ) u_stage (
            .clk       (clk_i),
            .rst_n     (rst_ni),
            .clr       (clr_i),
            .en        (en_i),
            .prev_valid(vld_q[k-1]),
            .prev_data (data_q[k-1]),
            .valid     (vld_q[k]),
            .data      (data_q[k])
        );
    end

    // Tap mux: out-of-range selects clamp to the last stage.
    always_comb begin
        sel_c    = (tap_sel_i > TapW'(Depth)) ? TapW'(Depth) : tap_sel_i;
        tap_mode = (sel_c == '0) ? TAP_PASS : TAP_STAGE;
        d_o      = d_i;
        valid_o  = valid_i;
        if (tap_mode == TAP_STAGE) begin
            for (int k = 1; k <= Depth; k++) begin
                if (sel_c == TapW'(k)) begin
                    d_o     = data_q[k];
                    valid_o = vld_q[k];
                end
            end
        end
    end

    // Occupancy tracks valids entering stage 1 and leaving the last stage.
    always_comb begin
        fill_d = fill_q;
        if (clr_i) begin
            fill_d = '0;
        end else if (en_i) begin
            fill_d = fill_q + CntW'(valid_i) - CntW'(vld_q[Depth]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill_o = fill_q;

    a_fill_range : assert property (@(posedge clk_i) disable iff (!rst_ni) fill_q <= CntW'(Depth))
        else $error("shift_reg_tap: fill out of range");

endmodule

// File: tb/tb_shift_reg_tap.sv
// Self-checking bench for shift_reg_tap (Depth=4, 8-bit words) against a history-queue model.
module tb_shift_reg_tap;

    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       clr_i = 1'b0;
    logic       en_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] d_i = '0;
    logic [2:0] tap_sel_i = '0;
    logic       valid_o;
    logic [7:0] d_o;
    logic [2:0] fill_o;

    int total = 0;
    int bad = 0;

    // Model: inputs of the most recent enabled cycles, newest first.
    logic       hv[$];
    logic [7:0] hd[$];

    shift_reg_tap #(
        .dtype(logic [7:0]),
        .Depth(DEPTH)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_i),
        .en_i     (en_i),
        .valid_i  (valid_i),
        .d_i      (d_i),
        .tap_sel_i(tap_sel_i),
        .valid_o  (valid_o),
        .d_o      (d_o),
        .fill_o   (fill_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_empty();
        hv.delete();
        hd.delete();
        for (int i = 0; i < DEPTH; i++) begin
            hv.push_back(1'b0);
            hd.push_back(8'h00);
        end
    endtask

    function automatic int model_fill();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(hv[i]);
        return n;
    endfunction

    task automatic check_outputs(input string tag);
        int         s;
        logic       ev;
        logic [7:0] ed;
        s = (int'(tap_sel_i) > DEPTH) ? DEPTH : int'(tap_sel_i);
        if (s == 0) begin
            ev = valid_i;
            ed = d_i;
        end else begin
            ev = hv[s-1];
            ed = hd[s-1];
        end
        chk({tag, ".valid"}, {7'd0, valid_o}, {7'd0, ev});
`ifdef SHIFT_REG_TAP_DATA_GATE_EN
        if (ev) chk({tag, ".data"}, d_o, ed);
`else
        chk({tag, ".data"}, d_o, ed);
`endif
        chk({tag, ".fill"}, {5'd0, fill_o}, 8'(model_fill()));
    endtask

    // One clock: drive, check before the edge, advance the model at the edge.
    task automatic cycle(input string tag, input logic en, input logic clr, input logic v,
                         input logic [7:0] d, input logic [2:0] sel);
        en_i = en;
        clr_i = clr;
        valid_i = v;
        d_i = d;
        tap_sel_i = sel;
        #2;
        check_outputs(tag);
        @(posedge clk_i);
        if (clr) begin
            model_empty();
        end else if (en) begin
            hv.push_front(v);
            hd.push_front(d);
            void'(hv.pop_back());
            void'(hd.pop_back());
        end
        #1;
    endtask

    initial begin
        logic [7:0] sweep_exp [6];
        logic [2:0] frozen_fill;
        sweep_exp = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h01};
        model_empty();

        // Reset state
        #12;
        chk("reset.fill", {5'd0, fill_o}, 8'h00);
        tap_sel_i = 3'd4;
        #1;
        chk("reset.valid", {7'd0, valid_o}, 8'h00);
        chk("reset.data", d_o, 8'h00);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill with 0x1..0x8 at tap 4
        for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b0, 1'b1, 8'(i), 3'd4);
        chk("fill.full", {5'd0, fill_o}, 8'h04);

        // Stall with the line holding 0x3..0x6 (refill after clear)
        cycle("clr0", 1'b1, 1'b1, 1'b0, 8'h00, 3'd4);
        for (int i = 3; i <= 6; i++) cycle("load", 1'b1, 1'b0, 1'b1, 8'(i), 3'd4);
        frozen_fill = fill_o;
        for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'b0, 1'b1, 8'hEE, 3'd4);
        chk("hold.fill", {5'd0, fill_o}, {5'd0, frozen_fill});
        tap_sel_i = 3'd4;
        #1;
        chk("hold.d3", d_o, 8'h03);
        for (int i = 7; i <= 9; i++) cycle("resume", 1'b1, 1'b0, 1'b1, 8'(i), 3'd4);

        // Clear has priority and discards the presented word
        cycle("clr", 1'b1, 1'b1, 1'b1, 8'h0A, 3'd1);
        for (int s = 1; s <= DEPTH; s++) begin
            tap_sel_i = 3'(s);
            #1;
            chk("clr.valid", {7'd0, valid_o}, 8'h00);
            chk("clr.data", d_o, 8'h00);
        end
        chk("clr.fill", {5'd0, fill_o}, 8'h00);

        // Tap sweep over a full line of 0x4,0x3,0x2,0x1
        for (int i = 1; i <= 4; i++) cycle("pre", 1'b1, 1'b0, 1'b1, 8'(i), 3'd0);
        en_i = 1'b0;
        valid_i = 1'b1;
        d_i = 8'h05;
        for (int s = 0; s <= 5; s++) begin
            tap_sel_i = 3'(s);
            #1;
            chk("sweep", d_o, sweep_exp[s]);
            check_outputs("sweep");
        end
        @(posedge clk_i);
        #1;

        // Alternating valid
        cycle("clr1", 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);
        for (int i = 0; i < 8; i++) cycle("alt", 1'b1, 1'b0, (i % 2) == 0, 8'hF0 + 8'(i), 3'(i % 5));
        chk("alt.fill", {5'd0, fill_o}, 8'h02);

        // Asynchronous reset mid-stream with fill=3
        cycle("clr2", 1'b1, 1'b1, 1'b0, 8'h00, 3'd4);
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 1'b0, 1'b1, 8'h30 + 8'(i), 3'd3);
        chk("pre_rst.fill", {5'd0, fill_o}, 8'h03);
        en_i = 1'b0;
        tap_sel_i = 3'd3;
        rst_ni = 1'b0;
        #1;
        chk("arst.valid", {7'd0, valid_o}, 8'h00);
        chk("arst.data", d_o, 8'h00);
        chk("arst.fill", {5'd0, fill_o}, 8'h00);
        model_empty();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst.fill", {5'd0, fill_o}, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", $urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0,
                  1'($urandom), 8'($urandom), 3'($urandom_range(7, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
